// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t   : sequencer FSM states (HALT is only reachable when
//                     FETCH_HALT_ON_WRAP_EN is defined)
//   OPCODE_WIDTH    : width of the opcode field at the top of the instruction
//   STIN_OP, NOP_OPCODE_C : opcode values taken from the core's opcode macros
//   NOP_WORD        : instruction word shown to the decoder when nothing is valid
//                     (default 24-bit instruction width)
//   is_stin()       : helper that recognises the input-switch instruction

// Opcode values normally come from the core's opcodes.sv; the defaults here
// keep this slice self-contained and step aside if opcodes.sv is already loaded.
`ifndef STIN
`define STIN 6'b010000
`endif
`ifndef NOP_OPCODE
`define NOP_OPCODE 6'b000000
`endif

package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int          OPCODE_WIDTH = 6;
    localparam logic [5:0]  STIN_OP      = `STIN;
    localparam logic [5:0]  NOP_OPCODE_C = `NOP_OPCODE;
    localparam logic [23:0] NOP_WORD     = {NOP_OPCODE_C, 18'h00000};

    function automatic logic is_stin(input logic [5:0] op);
        return (op == STIN_OP);
    endfunction

endpackage

// File: rtl/branch_target.sv
// branch_target: combinational PC-relative target computation.
//   base_i   : address of the branching instruction (dec_pc)
//   offset_i : signed branch offset from the instruction word
//   target_o : base + sign_extend(offset), modulo 2^PC_WIDTH
// Works for any relation between PC_WIDTH and OFFSET_WIDTH: the add is done
// in a width large enough for both operands and then truncated.

module branch_target #(
    parameter int PC_WIDTH     = 8,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0]     base_i,
    input  logic [OFFSET_WIDTH-1:0] offset_i,
    output logic [PC_WIDTH-1:0]     target_o
);

    localparam int SUM_W = PC_WIDTH + OFFSET_WIDTH;

    logic [SUM_W-1:0] offset_ext_s;
    logic [SUM_W-1:0] base_ext_s;
    logic [SUM_W-1:0] sum_s;

    assign offset_ext_s = {{PC_WIDTH{offset_i[OFFSET_WIDTH-1]}}, offset_i};
    assign base_ext_s   = {{OFFSET_WIDTH{1'b0}}, base_i};
    assign sum_s        = base_ext_s + offset_ext_s;
    assign target_o     = sum_s[PC_WIDTH-1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch front end of the pico MIPS decoder.
//   clk, reset     : single clock, synchronous active-high reset
//   prog_addr      : program ROM address (ROM answers one cycle later)
//   prog_data      : program ROM read data
//   instr, opcode  : instruction in decode and its opcode field (NOP when invalid)
//   instr_valid    : instr/opcode meaningful this cycle
//   dec_pc         : address of instr
//   pc_rel_branch  : decoder request to take a PC-relative branch
//   in_valid       : input-switch data available
//   in_ack         : one-cycle pulse when an STIN consumes the input
//   halted         : (FETCH_HALT_ON_WRAP_EN only) sequencer stopped at top of ROM
// Optional feature macro: FETCH_HALT_ON_WRAP_EN. When undefined the PC wraps
// silently; when defined, running sequentially past the last address halts.

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH     = 8,
    parameter int INSTR_WIDTH  = 24,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [5:0]             opcode,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    dec_pc,
    input  logic                   pc_rel_branch,
    input  logic                   in_valid,
    output logic                   in_ack
`ifdef FETCH_HALT_ON_WRAP_EN
    ,
    output logic                   halted
`endif
);

    localparam logic [PC_WIDTH-1:0]    PC_ZERO = {PC_WIDTH{1'b0}};
    localparam logic [PC_WIDTH-1:0]    PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INSTR_WIDTH-1:0] NOP_W   =
        {NOP_OPCODE_C, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};
`ifdef FETCH_HALT_ON_WRAP_EN
    localparam logic [PC_WIDTH-1:0]    PC_MAX  = {PC_WIDTH{1'b1}};
`endif

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   dec_pc_q, dec_pc_d;
    logic                  valid_q;
`ifdef FETCH_HALT_ON_WRAP_EN
    logic                  halted_q;
`endif

    logic                  run_s;
    logic                  stin_s;
    logic                  stall_s;
    logic                  branch_s;
    logic [PC_WIDTH-1:0]   pc_seq_s;
    logic [PC_WIDTH-1:0]   target_s;

    assign run_s    = (state_q == RUN);
    assign instr    = valid_q ? prog_data : NOP_W;
    assign opcode   = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign stin_s   = run_s && is_stin(opcode);
    assign stall_s  = stin_s && !in_valid;
    assign in_ack   = stin_s && in_valid;
    // An STIN never branches, so a stalled instruction ignores pc_rel_branch.
    assign branch_s = run_s && pc_rel_branch && !stall_s;

    // ROM address deliberately excludes pc_rel_branch: only the stall mux
    // sits on this path; a taken branch costs the one fetch it wastes.
    assign prog_addr = stall_s ? dec_pc_q : pc_q;

`ifdef FETCH_HALT_ON_WRAP_EN
    // Saturate so the last address is fetched and decoded before halting.
    assign pc_seq_s = (pc_q == PC_MAX) ? pc_q : (pc_q + PC_ONE);
`else
    assign pc_seq_s = pc_q + PC_ONE;
`endif

    branch_target #(
        .PC_WIDTH     (PC_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_branch_target (
        .base_i   (dec_pc_q),
        .offset_i (instr[OFFSET_WIDTH-1:0]),
        .target_o (target_s)
    );

    // Next-state and next-PC selection for the fetch FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dec_pc_d = dec_pc_q;
        case (state_q)
            BOOT: begin
                pc_d     = pc_seq_s;
                dec_pc_d = pc_q;
                state_d  = RUN;
            end
            RUN: begin
                if (stall_s) begin
                    pc_d     = pc_q;
                    dec_pc_d = dec_pc_q;
                end else if (branch_s) begin
                    pc_d     = target_s;
                    dec_pc_d = target_s;
                    state_d  = FLUSH;
                end
`ifdef FETCH_HALT_ON_WRAP_EN
                else if (dec_pc_q == PC_MAX) begin
                    state_d = HALT;
                end
`endif
                else begin
                    pc_d     = pc_seq_s;
                    dec_pc_d = pc_q;
                end
            end
            FLUSH: begin
                pc_d    = pc_seq_s;
                state_d = RUN;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d  = BOOT;
                pc_d     = PC_ZERO;
                dec_pc_d = PC_ZERO;
            end
        endcase
    end

    // State, PC and registered status outputs; reset wins over every event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= PC_ZERO;
            dec_pc_q <= PC_ZERO;
            valid_q  <= 1'b0;
`ifdef FETCH_HALT_ON_WRAP_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dec_pc_q <= dec_pc_d;
            valid_q  <= (state_d == RUN);
`ifdef FETCH_HALT_ON_WRAP_EN
            halted_q <= (state_d == HALT);
`endif
        end
    end

    assign instr_valid = valid_q;
    assign dec_pc      = dec_pc_q;
`ifdef FETCH_HALT_ON_WRAP_EN
    assign halted      = halted_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer. Two instances share
// clock and reset: an 8-bit-PC one for the main flow and a 4-bit-PC one for
// the wrap / halt boundary. Each has a synchronous ROM model and the 8-bit one
// has a tiny decoder model that raises pc_rel_branch for JMP and taken BEQ.

module tb_fetch_sequencer;

    localparam logic [5:0] OP_STIN = 6'h10;
    localparam logic [5:0] OP_JMP  = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h03;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  prog_addr, dec_pc;
    logic [23:0] prog_data, instr;
    logic [5:0]  opcode;
    logic        instr_valid, pc_rel_branch, in_valid, in_ack;
    logic        beq_take;

    logic [3:0]  prog_addr4, dec_pc4;
    logic [23:0] prog_data4, instr4;
    logic [5:0]  opcode4;
    logic        instr_valid4, in_ack4;
`ifdef FETCH_HALT_ON_WRAP_EN
    logic        halted, halted4;
`endif

    logic [23:0] rom  [256];
    logic [23:0] rom4 [16];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) prog_data  <= rom[prog_addr];
    always @(posedge clk) prog_data4 <= rom4[prog_addr4];

    assign pc_rel_branch = instr_valid &&
                           ((opcode == OP_JMP) || ((opcode == OP_BEQ) && beq_take));

    fetch_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(24), .OFFSET_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .dec_pc(dec_pc),
        .pc_rel_branch(pc_rel_branch), .in_valid(in_valid), .in_ack(in_ack)
`ifdef FETCH_HALT_ON_WRAP_EN
        , .halted(halted)
`endif
    );

    fetch_sequencer #(.PC_WIDTH(4), .INSTR_WIDTH(24), .OFFSET_WIDTH(8)) u_dut4 (
        .clk(clk), .reset(reset), .prog_addr(prog_addr4), .prog_data(prog_data4),
        .instr(instr4), .opcode(opcode4), .instr_valid(instr_valid4), .dec_pc(dec_pc4),
        .pc_rel_branch(1'b0), .in_valid(1'b1), .in_ack(in_ack4)
`ifdef FETCH_HALT_ON_WRAP_EN
        , .halted(halted4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        beq_take = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 24'(i);
        for (int i = 0; i < 16; i++) rom4[i] = 24'(i);

        // Reset state and linear fetch (ROM[i] = i).
        reset = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_dec_pc", 32'(dec_pc), 32'd0);
        chk("rst_addr", 32'(prog_addr), 32'd0);
        chk("rst_ack", 32'(in_ack), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        reset = 1'b0;
        #1;
        chk("boot_addr", 32'(prog_addr), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("seq_addr", 32'(prog_addr), 32'(k));
            chk("seq_valid", 32'(instr_valid), 32'd1);
            chk("seq_dec_pc", 32'(dec_pc), 32'(k - 1));
            chk("seq_instr", 32'(instr), 32'(k - 1));
        end

        // STIN stall at 2, JMP -2 at 3, then reset colliding with a branch.
        rom[2] = 24'h400002;
        rom[3] = 24'h0800FE;
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_dec_pc", 32'(dec_pc), 32'd2);
            chk("stall_addr", 32'(prog_addr), 32'd2);
            chk("stall_ack", 32'(in_ack), 32'd0);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        chk("stin_opcode", 32'(opcode), 32'(OP_STIN));
        step();
        in_valid = 1'b1;
        #1;
        chk("release_dec_pc", 32'(dec_pc), 32'd2);
        chk("release_ack", 32'(in_ack), 32'd1);
        chk("release_addr", 32'(prog_addr), 32'd3);
        step();
        chk("jmp_dec_pc", 32'(dec_pc), 32'd3);
        chk("jmp_instr", 32'(instr), 32'h0800FE);
        chk("jmp_ack", 32'(in_ack), 32'd0);
        chk("jmp_addr", 32'(prog_addr), 32'd4);
        step();
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_instr", 32'(instr), 32'd0);
        chk("flush_addr", 32'(prog_addr), 32'd1);
        step();
        chk("tgt_valid", 32'(instr_valid), 32'd1);
        chk("tgt_dec_pc", 32'(dec_pc), 32'd1);
        chk("tgt_instr", 32'(instr), 32'd1);
        chk("tgt_addr", 32'(prog_addr), 32'd2);
        step();
        chk("nostall_dec_pc", 32'(dec_pc), 32'd2);
        chk("nostall_ack", 32'(in_ack), 32'd1);
        chk("nostall_addr", 32'(prog_addr), 32'd3);
        step();
        chk("jmp2_dec_pc", 32'(dec_pc), 32'd3);
        chk("jmp2_branch", 32'(pc_rel_branch), 32'd1);
        reset = 1'b1;
        step();
        chk("rstbr_valid", 32'(instr_valid), 32'd0);
        chk("rstbr_dec_pc", 32'(dec_pc), 32'd0);
        chk("rstbr_addr", 32'(prog_addr), 32'd0);
        reset = 1'b0;
        step();
        chk("rstbr_run_valid", 32'(instr_valid), 32'd1);
        chk("rstbr_run_dec_pc", 32'(dec_pc), 32'd0);
        chk("rstbr_run_addr", 32'(prog_addr), 32'd1);

        // BEQ not taken at 5 (no bubble), BEQ +3 taken at 7 (target 10).
        rom[2] = 24'h000002;
        rom[3] = 24'h000003;
        rom[5] = 24'h0C0005;
        rom[7] = 24'h0C0003;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("beq_dec_pc", 32'(dec_pc), 32'd5);
        chk("beq_opcode", 32'(opcode), 32'(OP_BEQ));
        chk("beq_addr", 32'(prog_addr), 32'd6);
        step();
        chk("beq_nt_valid", 32'(instr_valid), 32'd1);
        chk("beq_nt_dec_pc", 32'(dec_pc), 32'd6);
        beq_take = 1'b1;
        step();
        chk("beq_t_dec_pc", 32'(dec_pc), 32'd7);
        step();
        chk("beq_t_flush", 32'(instr_valid), 32'd0);
        chk("beq_t_addr", 32'(prog_addr), 32'd10);
        step();
        chk("beq_t_dec_pc2", 32'(dec_pc), 32'd10);
        chk("beq_t_instr", 32'(instr), 32'd10);
        beq_take = 1'b0;

        // 4-bit PC boundary: linear run up to address 15.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 15; k++) step();
        chk("w4_addr15", 32'(prog_addr4), 32'd15);
        chk("w4_dec_pc14", 32'(dec_pc4), 32'd14);
        step();
        chk("w4_dec_pc15", 32'(dec_pc4), 32'd15);
        chk("w4_valid15", 32'(instr_valid4), 32'd1);
        chk("w4_instr15", 32'(instr4), 32'd15);
`ifdef FETCH_HALT_ON_WRAP_EN
        chk("w4_addr_sat", 32'(prog_addr4), 32'd15);
        chk("w4_not_halted", 32'(halted4), 32'd0);
        step();
        chk("w4_halt_valid", 32'(instr_valid4), 32'd0);
        chk("w4_halted", 32'(halted4), 32'd1);
        step();
        chk("w4_halted_hold", 32'(halted4), 32'd1);
        chk("w4_halt_addr", 32'(prog_addr4), 32'd15);
        chk("w8_not_halted", 32'(halted), 32'd0);
`else
        chk("w4_addr_wrap", 32'(prog_addr4), 32'd0);
        step();
        chk("w4_wrap_dec_pc", 32'(dec_pc4), 32'd0);
        chk("w4_wrap_addr", 32'(prog_addr4), 32'd1);
        chk("w4_wrap_valid", 32'(instr_valid4), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
